ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//   Execute-to-memory stage directly downstream of the ALU. Consumes data_result,
//   isNotEqual, isLessThan and overflow for the instruction in EX.
//   Resolves bne/blt and raises a one-cycle PC redirect.
//   Rewrites overflowing add/addi/sub into a $rstatus (r30) write with the ISA code.
//   Latches the result into the EX/MEM pipeline register, with stall and flush.
// PARAMETERS
//   RSTATUS_REG  5'd30  destination register for overflow status writes
//   CODE_ADD     32'd1  status value for add overflow
//   CODE_ADDI    32'd2  status value for addi overflow
//   CODE_SUB     32'd3  status value for sub overflow
// PORTS
//   clock           in   1   single clock; all state updates on posedge
//   reset           in   1   asynchronous, active-high; clears all state
//   stall           in   1   hold EX/MEM contents (memory-side back-pressure)
//   flush           in   1   kill EX/MEM contents and any pending redirect
//   in_valid        in   1   EX holds a live instruction
//   in_pc           in   32  PC of the EX instruction (word address)
//   in_insn         in   32  instruction word: [31:27] opcode, [26:22] rd, [16:0] imm
//   in_dataB        in   32  $rd value, passed through as store data
//   alu_result      in   32  ALU data_result
//   alu_ne          in   1   ALU isNotEqual (A=$rd, B=$rs, ALU op 00001)
//   alu_lt          in   1   ALU isLessThan
//   alu_ovf         in   1   ALU overflow
//   out_valid       out  1   EX/MEM holds a live instruction
//   out_pc          out  32  latched PC
//   out_insn        out  32  latched instruction word
//   out_result      out  32  ALU result, or status code when an overflow is converted
//   out_dataB       out  32  latched store data
//   out_rd          out  5   write-back register; RSTATUS_REG when an overflow is converted
//   out_we          out  1   register write enable (0 for sw, bne, blt, j, jr, bubbles)
//   redirect_valid  out  1   one-cycle pulse: branch taken
//   redirect_pc     out  32  branch target = pc + 1 + sext(imm17)
// BEHAVIOUR
//   Reset: every output is 0 immediately on reset rise; registers stay 0 until the
//     first posedge after reset falls.
//   Latency: one cycle; EX inputs at posedge N appear on out_* after posedge N.
//   Priority at each posedge: reset > flush > redirect-squash > stall > capture.
//     flush: out_valid=0, out_we=0, redirect_valid=0; other fields don't-care, hold.
//     redirect-squash: while redirect_valid=1, the EX instruction is wrong-path.
//       It is captured as a bubble (out_valid=0), even if stall=1.
//     stall: all out_* hold. redirect_valid is a pulse and still drops to 0.
//     capture: latch the inputs. in_valid=0 gives out_valid=0 and out_we=0.
//   Branch resolution (in_valid=1, not stalled, not squashed):
//     bne (00010) is taken when alu_ne=1; blt (00110) is taken when alu_lt=1.
//     When taken, redirect_valid=1 and redirect_pc are registered at that posedge.
//     redirect_pc = in_pc + 1 + {{15{imm[16]}},imm}, modulo 2^32 (wraps).
//     Upstream IF/ID and ID/EX clear on redirect_valid regardless of their own stall.
//   Overflow conversion (in_valid=1, alu_ovf=1):
//     add (opcode 00000, ALU op 00000): out_rd=RSTATUS_REG, out_result=CODE_ADD, out_we=1.
//     sub (opcode 00000, ALU op 00001): out_rd=RSTATUS_REG, out_result=CODE_SUB, out_we=1.
//     addi (opcode 00101): out_rd=RSTATUS_REG, out_result=CODE_ADDI, out_we=1.
//     alu_ovf on any other opcode is ignored.
//   Write enable: out_we=1 for R-type, addi, lw and jal (rd=31).
//     out_rd=0 forces out_we=0, except for converted overflows.
//   Back-to-back taken branches: the second one sits in the squash slot and is dropped.
//   Simultaneous flush and taken branch: flush wins, no redirect is issued.
// STRUCTURE
//   Shared include isa_defs.vh: opcode constants (ALU, ADDI, SW, LW, J, BNE, JAL,
//     JR, BLT), ALU op constants, and RSTATUS_REG and CODE_* defaults.
//   One combinational sub-module, branch_unit (opcode, ne, lt, pc, imm -> taken, target).
//   The EX/MEM register and the redirect register live in the top module.
// TESTING
//   1 add, alu_result=32'h5, no ovf, rd=3 -> next cycle out_rd=3, out_result=5, out_we=1.
//   2 add, alu_ovf=1, rd=7 -> out_rd=30, out_result=1. Same with sub gives 3; addi gives 2.
//   3 bne at pc=32'h10, imm=17'h1FFFE, alu_ne=1 -> redirect_valid for exactly 1 cycle,
//     redirect_pc=32'hF. The next EX instruction gives out_valid=0.
//   4 blt alu_lt=0 -> no redirect, out_we=0. blt at pc=32'hFFFFFFFF, imm=0, alu_lt=1
//     -> redirect_pc=32'h0.
//   5 stall held 3 cycles with a live add -> out_* hold; release -> next instruction latched.
//     flush with a taken bne -> out_valid=0, no redirect.
//   6 reset asserted mid-stream, off the clock edge -> all outputs 0 at once; first
//     posedge after release captures normally.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared ISA definitions for the execute-to-memory stage: opcodes, ALU ops,
// overflow status defaults and the EX/MEM pipeline register layout.
package ex_mem_stage_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    localparam logic [4:0]  LINK_REG         = 5'd31;
    localparam logic [4:0]  DEF_RSTATUS_REG  = 5'd30;
    localparam logic [31:0] DEF_CODE_ADD     = 32'd1;
    localparam logic [31:0] DEF_CODE_ADDI    = 32'd2;
    localparam logic [31:0] DEF_CODE_SUB     = 32'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] result;
        logic [31:0] data_b;
        logic [4:0]  rd;
        logic        we;
    } ex_mem_t;

    function automatic logic [31:0] sext17(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_unit.sv
// Combinational bne/blt resolution and PC-relative target computation.
module branch_unit
    import ex_mem_stage_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic        ne,
    input  logic        lt,
    input  logic [31:0] pc,
    input  logic [16:0] imm,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        taken  = ((opcode == OP_BNE) && ne) || ((opcode == OP_BLT) && lt);
        target = pc + 32'd1 + sext17(imm);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect generation and conversion of
// arithmetic overflow into a $rstatus write.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter logic [4:0]  RSTATUS_REG = DEF_RSTATUS_REG,
    parameter logic [31:0] CODE_ADD    = DEF_CODE_ADD,
    parameter logic [31:0] CODE_ADDI   = DEF_CODE_ADDI,
    parameter logic [31:0] CODE_SUB    = DEF_CODE_SUB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_dataB,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_insn,
    output logic [31:0] out_result,
    output logic [31:0] out_dataB,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [4:0]  wr_rd;
    logic        we_class;
    logic        ovf_conv;
    logic [31:0] ovf_code;
    logic        taken;
    logic [31:0] target;
    ex_mem_t     cap;
    ex_mem_t     q;
    logic        redir_valid_q;
    logic [31:0] redir_pc_q;

    assign opcode = in_insn[31:27];
    assign alu_op = in_insn[6:2];

    branch_unit u_branch (
        .opcode (opcode),
        .ne     (alu_ne),
        .lt     (alu_lt),
        .pc     (in_pc),
        .imm    (in_insn[16:0]),
        .taken  (taken),
        .target (target)
    );

    // Converted overflows write the status register even though rd may be 0.
    always_comb begin
        ovf_conv = 1'b0;
        ovf_code = 32'd0;
        if (alu_ovf) begin
            if (opcode == OP_ALU && alu_op == ALU_ADD) begin
                ovf_conv = 1'b1;
                ovf_code = CODE_ADD;
            end else if (opcode == OP_ALU && alu_op == ALU_SUB) begin
                ovf_conv = 1'b1;
                ovf_code = CODE_SUB;
            end else if (opcode == OP_ADDI) begin
                ovf_conv = 1'b1;
                ovf_code = CODE_ADDI;
            end
        end

        wr_rd    = (opcode == OP_JAL) ? LINK_REG : in_insn[26:22];
        we_class = (opcode == OP_ALU) || (opcode == OP_ADDI) ||
                   (opcode == OP_LW)  || (opcode == OP_JAL);

        cap.valid  = in_valid;
        cap.pc     = in_pc;
        cap.insn   = in_insn;
        cap.data_b = in_dataB;
        cap.result = ovf_conv ? ovf_code : alu_result;
        cap.rd     = ovf_conv ? RSTATUS_REG : wr_rd;
        cap.we     = in_valid && (ovf_conv || (we_class && (wr_rd != 5'd0)));
    end

    // While a redirect is outstanding the EX slot holds a wrong-path instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q             <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
        end else if (flush || redir_valid_q) begin
            q.valid       <= 1'b0;
            q.we          <= 1'b0;
            redir_valid_q <= 1'b0;
        end else if (stall) begin
            redir_valid_q <= 1'b0;
        end else begin
            q             <= cap;
            redir_valid_q <= in_valid && taken;
            if (in_valid && taken) begin
                redir_pc_q <= target;
            end
        end
    end

    assign out_valid      = q.valid;
    assign out_pc         = q.pc;
    assign out_insn       = q.insn;
    assign out_result     = q.result;
    assign out_dataB      = q.data_b;
    assign out_rd         = q.rd;
    assign out_we         = q.we;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

endmodule
